alu: RTL and testbench
======================

ALU -- requirements
Module: alu

Interface
REQ-001 Parameter XLEN, default 64, datapath width; all requirements below are written for XLEN=64.
REQ-002 clk_i  input  1  single clock; one clock; samples the registered output copies only.
REQ-003 rst_i  input  1  reset, asynchronous, active-high.
REQ-004 data1_i  input  64  operand A (rs1 or PC).
REQ-005 data2_i  input  64  operand B (rs2 or immediate).
REQ-006 ALUOp_i  input  2  operation class from main control.
REQ-007 ALUControl_i  input  4  operation select from ALU control.
REQ-008 result_o  output  64  combinational result.
REQ-009 zero  output  1  combinational flag, 1 when result_o == 0.
REQ-010 result_q_o  output  64  result_o registered on rising clk_i.
REQ-011 zero_q_o  output  1  zero registered on rising clk_i.

Function
REQ-012 result_o and zero shall be purely combinational, with zero-cycle latency from any input change.
REQ-013 ALUOp_i=00 (load/store address) shall force ADD: data1_i + data2_i, modulo 2^64, with ALUControl_i ignored.
REQ-014 ALUOp_i=01 (branch compare) shall force SUB: data1_i - data2_i, modulo 2^64, with ALUControl_i ignored.
REQ-015 ALUOp_i=10 (R/I-type) shall decode ALUControl_i as follows:
- 0000 AND
- 0001 OR
- 0010 ADD
- 0011 XOR
- 0100 SLL
- 0101 SRL
- 0110 SUB
- 0111 SLT
- 1000 SLTU
- 1001 SRA
REQ-016 Any other ALUControl_i code under ALUOp_i=10 or 11 shall yield result_o = 0 (and therefore zero = 1).
REQ-017 ALUOp_i=11 (RV64 W-ops) shall apply the same ALUControl_i decode to the low 32 bits for ADD, SUB, SLL, SRL and SRA, then sign-extend bit 31 of the 32-bit result to 64 bits.
REQ-018 Under ALUOp_i=11, logic and compare codes (AND, OR, XOR, SLT, SLTU) shall behave exactly as under ALUOp_i=10.
REQ-019 Shift amount:
- 64-bit shifts use data2_i[5:0].
- W shifts use data2_i[4:0].
- All other bits of data2_i are ignored.
REQ-020 SRA and SRAW shall replicate the operand sign bit (bit 63, or bit 31 for the W form); SRL and SRLW shall fill with zeros.
REQ-021 SLT (signed) and SLTU (unsigned) shall return 64'h1 when data1_i < data2_i, else 64'h0.
REQ-022 ADD and SUB shall wrap silently; no overflow or carry output is provided.
REQ-023 On every rising clk_i edge while rst_i is low, result_q_o and zero_q_o shall load the current result_o and zero.

Reset
REQ-024 While rst_i is high, result_q_o shall be 0 and zero_q_o shall be 0, asynchronously and regardless of clk_i.
REQ-025 Reset shall not affect result_o or zero, which track the inputs at all times.
REQ-026 After rst_i deasserts, the first rising clk_i edge shall capture normally.

Structure
REQ-027 The ALUOp and ALUControl encodings shall be defined as named enums/constants in a shared package alu_pkg, reused by the control unit.
REQ-028 The decode plus compute logic shall be a single combinational block; the W-op sign-extension shall be a separate small sub-module alu_sext32.
REQ-029 The output register shall be one always_ff block with asynchronous reset.

Verification
REQ-030 Load address: A=0xA, B=0x14, ALUOp=00, ctrl=0010 -> result_o = 0x1E, zero = 0.
REQ-031 Branch: A=B=0xA, ALUOp=01 -> result_o = 0, zero = 1.
REQ-032 Arithmetic, ALUOp=10:
- ADD 0x3C+0x14 -> 0x50.
- SUB 0x1E-0xF -> 0xF.
- SUB 0-1 -> 0xFFFFFFFFFFFFFFFF.
REQ-033 Logic, ALUOp=10, with A=0xFFFFFFFFFFFFFFFF and B=0xFFFF:
- AND -> 0xFFFF.
- OR -> 0xFFFFFFFFFFFFFFFF.
- XOR -> 0xFFFFFFFFFFFF0000.
REQ-034 Shifts and compares:
- SRA A=0x8000000000000000, B=4 -> 0xF800000000000000.
- SLT A=-1, B=1 -> 1.
- SLTU A=-1, B=1 -> 0.
- ADDW A=0x7FFFFFFF, B=1 -> 0xFFFFFFFF80000000.
REQ-035 Register: assert rst_i mid-cycle -> result_q_o and zero_q_o go to 0 immediately; release and clock with ADD 1+0x14 -> result_q_o = 0x15 one edge later.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared encodings for the ALU: operation class from main control and
// operation select from ALU control. The control unit imports these too.
package alu_pkg;

    localparam int unsigned XLEN_DEFAULT = 64;

    typedef enum logic [1:0] {
        ALUOP_MEM    = 2'b00,   // load/store address: always ADD
        ALUOP_BRANCH = 2'b01,   // branch compare: always SUB
        ALUOP_RTYPE  = 2'b10,   // R/I-type: decode ALUControl
        ALUOP_WORD   = 2'b11    // RV64 W-ops: 32-bit arithmetic, sign-extended
    } alu_op_e;

    typedef enum logic [3:0] {
        ALU_AND  = 4'b0000,
        ALU_OR   = 4'b0001,
        ALU_ADD  = 4'b0010,
        ALU_XOR  = 4'b0011,
        ALU_SLL  = 4'b0100,
        ALU_SRL  = 4'b0101,
        ALU_SUB  = 4'b0110,
        ALU_SLT  = 4'b0111,
        ALU_SLTU = 4'b1000,
        ALU_SRA  = 4'b1001
    } alu_ctrl_e;

endpackage

// File: rtl/alu_sext32.sv
// Sign-extends a 32-bit W-op result to the full datapath width.
module alu_sext32 #(
    parameter int unsigned XLEN = 64
) (
    input  logic [31:0]     word,
    output logic [XLEN-1:0] ext
);

    assign ext = {{(XLEN-32){word[31]}}, word};

endmodule

// File: rtl/alu.sv
// RV64 ALU: combinational result and zero flag, plus a registered copy of
// both with asynchronous active-high reset.
module alu
    import alu_pkg::*;
#(
    parameter int unsigned XLEN = 64
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [XLEN-1:0] data1_i,
    input  logic [XLEN-1:0] data2_i,
    input  logic [1:0]      ALUOp_i,
    input  logic [3:0]      ALUControl_i,
    output logic [XLEN-1:0] result_o,
    output logic            zero,
    output logic [XLEN-1:0] result_q_o,
    output logic            zero_q_o
);

    localparam int unsigned SHW = $clog2(XLEN);

    logic [XLEN-1:0] full_res;   // full-width result (also used for W-op logic/compare)
    logic [31:0]     word_res;   // raw 32-bit result of a W arithmetic/shift op
    logic            use_word;   // select the sign-extended word result
    logic [XLEN-1:0] word_ext;
    logic [SHW-1:0]  shamt;
    logic [4:0]      shamt_w;
    logic [31:0]     a_w;
    logic [31:0]     b_w;

    assign shamt   = data2_i[SHW-1:0];
    assign shamt_w = data2_i[4:0];
    assign a_w     = data1_i[31:0];
    assign b_w     = data2_i[31:0];

    // Decode ALUOp/ALUControl and compute both the full-width and word results.
    always_comb begin
        full_res = '0;
        word_res = '0;
        use_word = 1'b0;
        unique case (alu_op_e'(ALUOp_i))
            ALUOP_MEM:    full_res = data1_i + data2_i;
            ALUOP_BRANCH: full_res = data1_i - data2_i;
            default: begin
                // RTYPE and WORD share the logic/compare codes; the
                // arithmetic and shift codes split on the W form.
                case (ALUControl_i)
                    ALU_AND:  full_res = data1_i & data2_i;
                    ALU_OR:   full_res = data1_i | data2_i;
                    ALU_XOR:  full_res = data1_i ^ data2_i;
                    ALU_SLT:  full_res = {{(XLEN-1){1'b0}}, ($signed(data1_i) < $signed(data2_i))};
                    ALU_SLTU: full_res = {{(XLEN-1){1'b0}}, (data1_i < data2_i)};
                    ALU_ADD: begin
                        full_res = data1_i + data2_i;
                        word_res = a_w + b_w;
                        use_word = (ALUOp_i == ALUOP_WORD);
                    end
                    ALU_SUB: begin
                        full_res = data1_i - data2_i;
                        word_res = a_w - b_w;
                        use_word = (ALUOp_i == ALUOP_WORD);
                    end
                    ALU_SLL: begin
                        full_res = data1_i << shamt;
                        word_res = a_w << shamt_w;
                        use_word = (ALUOp_i == ALUOP_WORD);
                    end
                    ALU_SRL: begin
                        full_res = data1_i >> shamt;
                        word_res = a_w >> shamt_w;
                        use_word = (ALUOp_i == ALUOP_WORD);
                    end
                    ALU_SRA: begin
                        full_res = $unsigned($signed(data1_i) >>> shamt);
                        word_res = $unsigned($signed(a_w) >>> shamt_w);
                        use_word = (ALUOp_i == ALUOP_WORD);
                    end
                    default:  full_res = '0;   // unassigned codes yield zero
                endcase
            end
        endcase
    end

    alu_sext32 #(
        .XLEN (XLEN)
    ) u_sext32 (
        .word (word_res),
        .ext  (word_ext)
    );

    assign result_o = use_word ? word_ext : full_res;
    assign zero     = (result_o == '0);

    // Registered copy of result and zero; reset clears both immediately.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            result_q_o <= '0;
            zero_q_o   <= 1'b0;
        end else begin
            result_q_o <= result_o;
            zero_q_o   <= zero;
        end
    end

endmodule

// File: tb/tb_alu.sv
// Directed self-checking bench for the ALU: combinational decode vectors,
// W-op sign extension, unassigned codes, and the async-reset output register.
module tb_alu;

    logic        clk_i;
    logic        rst_i;
    logic [63:0] data1_i;
    logic [63:0] data2_i;
    logic [1:0]  ALUOp_i;
    logic [3:0]  ALUControl_i;
    logic [63:0] result_o;
    logic        zero;
    logic [63:0] result_q_o;
    logic        zero_q_o;

    int checks = 0;
    int errors = 0;

    alu #(.XLEN(64)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .data1_i      (data1_i),
        .data2_i      (data2_i),
        .ALUOp_i      (ALUOp_i),
        .ALUControl_i (ALUControl_i),
        .result_o     (result_o),
        .zero         (zero),
        .result_q_o   (result_q_o),
        .zero_q_o     (zero_q_o)
    );

    // 10 ns clock
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one combinational vector, let it settle, check result and zero.
    task automatic vec(input string tag, input logic [1:0] op, input logic [3:0] ctrl,
                       input logic [63:0] a, input logic [63:0] b, input logic [63:0] exp);
        ALUOp_i      = op;
        ALUControl_i = ctrl;
        data1_i      = a;
        data2_i      = b;
        #1;
        check(tag, result_o, exp);
        check({tag, "_zero"}, {63'd0, zero}, {63'd0, (exp == 64'd0)});
        $display("vec %-10s op=%b ctrl=%b a=%h b=%h result=%h zero=%b", tag, op, ctrl, a, b, result_o, zero);
    endtask

    initial begin
        rst_i        = 1'b1;
        data1_i      = '0;
        data2_i      = '0;
        ALUOp_i      = 2'b00;
        ALUControl_i = 4'b0000;
        #2;
        check("rst_result_q", result_q_o, 64'd0);
        check("rst_zero_q", {63'd0, zero_q_o}, 64'd0);

        @(negedge clk_i);
        rst_i = 1'b0;

        // Load/store and branch classes ignore ALUControl
        vec("ld_add",    2'b00, 4'b0010, 64'hA, 64'h14, 64'h1E);
        vec("ld_ignore", 2'b00, 4'b0110, 64'hA, 64'h14, 64'h1E);
        vec("br_eq",     2'b01, 4'b0000, 64'hA, 64'hA, 64'h0);
        vec("br_ne",     2'b01, 4'b0010, 64'h5, 64'h7, 64'hFFFF_FFFF_FFFF_FFFE);

        // R-type arithmetic and logic
        vec("add",   2'b10, 4'b0010, 64'h3C, 64'h14, 64'h50);
        vec("sub",   2'b10, 4'b0110, 64'h1E, 64'hF, 64'hF);
        vec("sub_wr",2'b10, 4'b0110, 64'h0, 64'h1, 64'hFFFF_FFFF_FFFF_FFFF);
        vec("and",   2'b10, 4'b0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF, 64'hFFFF);
        vec("or",    2'b10, 4'b0001, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF, 64'hFFFF_FFFF_FFFF_FFFF);
        vec("xor",   2'b10, 4'b0011, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF, 64'hFFFF_FFFF_FFFF_0000);

        // Shifts: only data2[5:0] counts
        vec("sra",   2'b10, 4'b1001, 64'h8000_0000_0000_0000, 64'h4, 64'hF800_0000_0000_0000);
        vec("srl",   2'b10, 4'b0101, 64'h8000_0000_0000_0000, 64'h4, 64'h0800_0000_0000_0000);
        vec("sll_sh",2'b10, 4'b0100, 64'h1, 64'h43, 64'h8);
        vec("sll63", 2'b10, 4'b0100, 64'h1, 64'h3F, 64'h8000_0000_0000_0000);

        // Compares
        vec("slt",   2'b10, 4'b0111, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'h1);
        vec("sltu",  2'b10, 4'b1000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'h0);

        // W-ops: 32-bit compute then sign-extend bit 31
        vec("addw",  2'b11, 4'b0010, 64'h7FFF_FFFF, 64'h1, 64'hFFFF_FFFF_8000_0000);
        vec("subw",  2'b11, 4'b0110, 64'h1_0000_0000, 64'h1, 64'hFFFF_FFFF_FFFF_FFFF);
        vec("sllw",  2'b11, 4'b0100, 64'h1, 64'h3F, 64'hFFFF_FFFF_8000_0000);
        vec("sraw",  2'b11, 4'b1001, 64'h8000_0000, 64'h4, 64'hFFFF_FFFF_F800_0000);
        vec("srlw",  2'b11, 4'b0101, 64'hFFFF_FFFF_8000_0000, 64'h4, 64'h0000_0000_0800_0000);
        vec("andw",  2'b11, 4'b0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF, 64'hFFFF);
        vec("sltw",  2'b11, 4'b0111, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'h1);

        // Unassigned codes yield zero
        vec("undef10", 2'b10, 4'b1010, 64'h1234, 64'h5678, 64'h0);
        vec("undef11", 2'b11, 4'b1111, 64'h1234, 64'h5678, 64'h0);

        // Register captures on the rising edge
        @(negedge clk_i);
        vec("reg_sub", 2'b10, 4'b0110, 64'h1E, 64'hF, 64'hF);
        @(posedge clk_i); #1;
        check("q_sub", result_q_o, 64'hF);
        check("q_sub_zero", {63'd0, zero_q_o}, 64'd0);
        $display("reg capture result_q=%h zero_q=%b", result_q_o, zero_q_o);

        vec("reg_br", 2'b01, 4'b0000, 64'hA, 64'hA, 64'h0);
        @(posedge clk_i); #1;
        check("q_br_zero", {63'd0, zero_q_o}, 64'd1);
        $display("reg capture result_q=%h zero_q=%b", result_q_o, zero_q_o);

        // Mid-cycle asynchronous reset
        #2;
        rst_i = 1'b1;
        #1;
        check("arst_q", result_q_o, 64'd0);
        check("arst_zero_q", {63'd0, zero_q_o}, 64'd0);
        $display("async reset result_q=%h zero_q=%b", result_q_o, zero_q_o);

        // Combinational path unaffected by reset; register held clear over an edge
        vec("rst_comb", 2'b00, 4'b0010, 64'h1, 64'h14, 64'h15);
        @(posedge clk_i); #1;
        check("rst_hold_q", result_q_o, 64'd0);

        // Release and capture on the first edge
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        check("rel_before_edge", result_q_o, 64'd0);
        @(posedge clk_i); #1;
        check("rel_q", result_q_o, 64'h15);
        check("rel_zero_q", {63'd0, zero_q_o}, 64'd0);
        $display("post-reset capture result_q=%h zero_q=%b", result_q_o, zero_q_o);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
